// File: rtl/systolic_deskew_collector_if.sv
// Host-side bundle for systolic_deskew_collector: skewed result stream in, aligned rows out.
// DESKEW_DROP_CNT_EN adds the drop_cnt status bus.
interface systolic_deskew_collector_if #(
  parameter int DIM  = 8,
  parameter int BITS = 64
);
  logic                in_en;
  logic                in_vld;
  logic [DIM*BITS-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [DIM*BITS-1:0] out_data;
  logic                q_full;
  logic                overflow;
  logic                mat_done;
`ifdef DESKEW_DROP_CNT_EN
  logic [15:0]         drop_cnt;

  modport master (output in_en, in_vld, in_data, out_ready,
                  input  out_valid, out_data, q_full, overflow, mat_done, drop_cnt);
  modport slave  (input  in_en, in_vld, in_data, out_ready,
                  output out_valid, out_data, q_full, overflow, mat_done, drop_cnt);
`else
  modport master (output in_en, in_vld, in_data, out_ready,
                  input  out_valid, out_data, q_full, overflow, mat_done);
  modport slave  (input  in_en, in_vld, in_data, out_ready,
                  output out_valid, out_data, q_full, overflow, mat_done);
`endif
endinterface

// File: rtl/systolic_deskew_collector.sv
// Removes the column skew of systolic-array results and queues aligned rows for the host.
// Define DESKEW_DROP_CNT_EN to add a saturating 16-bit count of dropped rows.
module systolic_deskew_collector #(
  parameter int DIM    = 8,
  parameter int BITS   = 64,
  parameter int QDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  systolic_deskew_collector_if.slave bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(DIM) + 1;
  localparam int RW = DIM * BITS;

  logic [RW-1:0] aligned;
  logic          push;

  // The last column arrives in step with the row it completes.
  assign aligned[(DIM-1)*BITS +: BITS] = bus.in_data[(DIM-1)*BITS +: BITS];

  for (genvar c = 0; c < DIM - 1; c++) begin : g_col
    localparam int N = DIM - 1 - c;
    logic [BITS-1:0] chain [N];

    // NOTE: state is updated with <= so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < N; k++) chain[k] <= '0;
      end else if (bus.in_en) begin
        chain[0] <= bus.in_data[c*BITS +: BITS];
        for (int k = 1; k < N; k++) chain[k] <= chain[k-1];
      end
    end

    assign aligned[c*BITS +: BITS] = chain[N-1];
  end

  if (DIM > 1) begin : g_vpipe
    logic [DIM-2:0] vpipe;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vpipe <= '0;
      end else if (bus.in_en) begin
        vpipe[0] <= bus.in_vld;
        for (int k = 1; k < DIM - 1; k++) vpipe[k] <= vpipe[k-1];
      end
    end

    assign push = bus.in_en & vpipe[DIM-2];
  end else begin : g_novpipe
    assign push = bus.in_en & bus.in_vld;
  end

  logic [RW-1:0] mem [QDEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [RW-1:0] head_q, head_nxt;
  logic          empty, full, pop, wr_en, drop;
  logic [CW-1:0] row_cnt;
  logic          mat_done_q, overflow_q;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !empty && bus.out_ready;
  assign wr_en      = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign rd_ptr_nxt = pop ? rd_ptr + (AW+1)'(1) : rd_ptr;

  // Next head: bypass the incoming row when it lands in the slot about to become the head.
  // NOTE: head_nxt gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    head_nxt = head_q;
    if (wr_en && (rd_ptr_nxt == wr_ptr)) begin
      head_nxt = aligned;
    end else if (rd_ptr_nxt != wr_ptr) begin
      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the row storage is cleared on reset too, so stale rows can never reappear.
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head_q     <= '0;
      row_cnt    <= '0;
      mat_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= aligned;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      rd_ptr     <= rd_ptr_nxt;
      head_q     <= head_nxt;
      mat_done_q <= 1'b0;
      if (drop) overflow_q <= 1'b1;
      if (pop) begin
        if (row_cnt == CW'(DIM - 1)) begin
          row_cnt    <= '0;
          mat_done_q <= 1'b1;
        end else begin
          row_cnt <= row_cnt + CW'(1);
        end
      end
    end
  end

`ifdef DESKEW_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

  assign bus.out_valid = !empty;
  assign bus.out_data  = head_q;
  assign bus.q_full    = full;
  assign bus.overflow  = overflow_q;
  assign bus.mat_done  = mat_done_q;
endmodule
